// File: rtl/lf_pkg.sv
// Shared definitions for the ADPLL loop-filter gear sequencer: gear encoding,
// vote widths and the gear-to-decimation lookup.
package lf_pkg;

    localparam logic [1:0] GEAR_ACQ = 2'd0;
    localparam logic [1:0] GEAR_TRK = 2'd1;
    localparam logic [1:0] GEAR_LCK = 2'd2;

    // Decimation group counter must reach D-1 = 3; group net spans -4..+4.
    localparam int DEC_CNT_W = 2;
    localparam int DEC_NET_W = 4;

    // Returns D-1 for the gear (D = 1, 2, 4); the unused code 3 decimates like ACQUIRE.
    function automatic logic [DEC_CNT_W-1:0] gear_dec_last(input logic [1:0] g);
        logic [DEC_CNT_W-1:0] last;
        case (g)
            GEAR_TRK: last = 2'd1;
            GEAR_LCK: last = 2'd3;
            default:  last = 2'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/lf_vote_acc.sv
// Signed early/late vote accumulator with sample count and terminal-count detect.
// done_o/sum_o are combinational on the current sample; state self-clears after the last one.
module lf_vote_acc #(
    parameter int CNT_W = 2,
    parameter int NET_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vld_i,
    input  logic                    early_i,
    input  logic                    clr_i,
    input  logic [CNT_W-1:0]        last_i,
    output logic                    done_o,
    output logic signed [NET_W-1:0] sum_o
);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [NET_W-1:0] net_q, net_d;
    logic signed [NET_W-1:0] vote;

    assign vote   = early_i ? {{(NET_W-1){1'b0}}, 1'b1} : {NET_W{1'b1}};
    assign done_o = vld_i && (cnt_q == last_i);
    assign sum_o  = net_q + vote;

    always_comb begin
        cnt_d = cnt_q;
        net_d = net_q;
        if (clr_i || done_o) begin
            cnt_d = '0;
            net_d = '0;
        end else if (vld_i) begin
            cnt_d = cnt_q + 1'b1;
            net_d = sum_o;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            net_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            net_q <= net_d;
        end
    end

endmodule

// File: rtl/lf_gear_ctrl.sv
// Gear-shifting sequencer: decimates PD votes into integrator steps, adapts gear
// to lock quality and turns integrator carries into DCO pulses. All outputs registered.
module lf_gear_ctrl
    import lf_pkg::*;
#(
    parameter int WIN_LOG2   = 4,
    parameter int LOCK_THR   = 4,
    parameter int UNLOCK_THR = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pd_valid,
    input  logic       pd_early,
    input  logic       overflow,
    input  logic       underflow,
    output logic       int_step,
    output logic       int_early,
    output logic       int_clear,
    output logic       dco_inc,
    output logic       dco_dec,
    output logic [1:0] gear,
    output logic       locked
);

    localparam int WIN_NET_W = WIN_LOG2 + 2;
    localparam logic [WIN_NET_W-1:0] LOCK_T   = WIN_NET_W'(LOCK_THR);
    localparam logic [WIN_NET_W-1:0] UNLOCK_T = WIN_NET_W'(UNLOCK_THR);

    logic [1:0] gear_q, gear_d, gear_cur;
    logic       step_q, step_d;
    logic       early_q, early_d;
    logic       clear_q;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       locked_q;

    logic                        dec_done;
    logic signed [DEC_NET_W-1:0] dec_sum;
    logic                        win_done;
    logic signed [WIN_NET_W-1:0] win_sum;
    logic [WIN_NET_W-1:0]        win_mag;
    logic                        promote, unlock, gear_chg;

    assign gear_cur = (gear_q == GEAR_TRK || gear_q == GEAR_LCK) ? gear_q : GEAR_ACQ;

    // A gear change restarts the decimation group so the new D applies from the next sample.
    lf_vote_acc #(.CNT_W(DEC_CNT_W), .NET_W(DEC_NET_W)) u_dec_acc (
        .clk     (clk),
        .reset   (reset),
        .vld_i   (pd_valid),
        .early_i (pd_early),
        .clr_i   (gear_chg),
        .last_i  (gear_dec_last(gear_cur)),
        .done_o  (dec_done),
        .sum_o   (dec_sum)
    );

    lf_vote_acc #(.CNT_W(WIN_LOG2), .NET_W(WIN_NET_W)) u_win_acc (
        .clk     (clk),
        .reset   (reset),
        .vld_i   (pd_valid),
        .early_i (pd_early),
        .clr_i   (1'b0),
        .last_i  ({WIN_LOG2{1'b1}}),
        .done_o  (win_done),
        .sum_o   (win_sum)
    );

    assign win_mag = win_sum[WIN_NET_W-1] ? WIN_NET_W'(-win_sum) : WIN_NET_W'(win_sum);
    assign promote = win_done && (win_mag <= LOCK_T);
    assign unlock  = win_done && (win_mag >= UNLOCK_T);

    always_comb begin
        gear_d = gear_cur;
        if (unlock)
            gear_d = GEAR_ACQ;
        else if (promote && gear_cur != GEAR_LCK)
            gear_d = gear_cur + 2'd1;
    end

    assign gear_chg = pd_valid && (gear_d != gear_cur);

    // Step uses the pre-change gear; an unlock clears the integrator instead of stepping it.
    assign step_d  = dec_done && (dec_sum != '0) && !unlock;
    assign early_d = step_d && !dec_sum[DEC_NET_W-1];
    assign inc_d   = overflow && !underflow && !unlock;
    assign dec_d   = underflow && !overflow && !unlock;

    always_ff @(posedge clk) begin
        if (reset) begin
            gear_q   <= GEAR_ACQ;
            step_q   <= 1'b0;
            early_q  <= 1'b0;
            clear_q  <= 1'b0;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            gear_q   <= gear_d;
            step_q   <= step_d;
            early_q  <= early_d;
            clear_q  <= unlock;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            locked_q <= (gear_d == GEAR_LCK);
        end
    end

    assign int_step  = step_q;
    assign int_early = early_q;
    assign int_clear = clear_q;
    assign dco_inc   = inc_q;
    assign dco_dec   = dec_q;
    assign gear      = gear_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_lf_gear_ctrl.sv
// Scoreboard bench for lf_gear_ctrl: each driven cycle queues the hand-computed
// outputs expected after the next rising edge; a monitor pops and compares them.
module tb_lf_gear_ctrl;

    logic       clk;
    logic       reset;
    logic       pd_valid, pd_early, overflow, underflow;
    logic       int_step, int_early, int_clear, dco_inc, dco_dec, locked;
    logic [1:0] gear;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];

    lf_gear_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .pd_valid  (pd_valid),
        .pd_early  (pd_early),
        .overflow  (overflow),
        .underflow (underflow),
        .int_step  (int_step),
        .int_early (int_early),
        .int_clear (int_clear),
        .dco_inc   (dco_inc),
        .dco_dec   (dco_dec),
        .gear      (gear),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector: {step, early(only while step), clear, inc, dec, gear[1:0], locked}
    task automatic drv(input logic rst, input logic v, input logic e, input logic ov,
                       input logic un, input logic [1:0] eg, input logic es,
                       input logic ee, input logic ec, input logic ei, input logic ed,
                       input string tag);
        @(negedge clk);
        reset     = rst;
        pd_valid  = v;
        pd_early  = e;
        overflow  = ov;
        underflow = un;
        exp_q.push_back({es, es & ee, ec, ei, ed, eg, (eg == 2'd2)});
        tag_q.push_back(tag);
    endtask

    // Monitor: compares every cycle that has a queued expectation, just after the edge.
    initial begin
        logic [7:0] exp_v, got_v;
        string      tag;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                tag   = tag_q.pop_front();
                got_v = {int_step, int_step & int_early, int_clear, dco_inc, dco_dec, gear, locked};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL %s t=%0t got {step,early,clr,inc,dec,gear,lock}=%b expected=%b",
                             tag, $time, got_v, exp_v);
                end
            end
        end
    end

    initial begin
        logic       e;
        logic [1:0] g;
        reset = 1'b1; pd_valid = 1'b0; pd_early = 1'b0; overflow = 1'b0; underflow = 1'b0;

        repeat (2) drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_state");

        for (int i = 0; i < 3; i++)
            drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "acq_early_step");
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_again");

        // ACQUIRE: every sample steps; net-zero window promotes to TRACK
        for (int i = 0; i < 16; i++) begin
            e = (i % 2 == 0);
            g = (i == 15) ? 2'd1 : 2'd0;
            drv(1'b0, 1'b1, e, 1'b0, 1'b0, g, 1'b1, e, 1'b0, 1'b0, 1'b0, "acq_window");
        end

        // TRACK: pairs E,L / E,(gap),E / L,L then alternating; window net 0 promotes to LOCKED
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "trk_EL_first");
        drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "trk_EL_nostep");
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "trk_EE_first");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "trk_gap_idle");
        drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "trk_EE_step_early");
        drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "trk_LL_first");
        drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "trk_LL_step_late");
        for (int i = 0; i < 10; i++) begin
            e = (i % 2 == 0);
            g = (i == 9) ? 2'd2 : 2'd1;
            drv(1'b0, 1'b1, e, 1'b0, 1'b0, g, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "trk_window");
        end

        // LOCKED: 16 early; step every 4th, last sample unlocks with overflow suppressed
        for (int i = 0; i < 16; i++) begin
            if (i == 15)
                drv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "lck_unlock_clear");
            else
                drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, (i % 4 == 3), 1'b1, 1'b0, 1'b0, 1'b0, "lck_dec4");
        end

        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "dco_inc");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "dco_inc_single");
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "dco_dec");
        drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "dco_cancel");

        // Back to TRACK, then reset 7 samples into its window
        for (int i = 0; i < 16; i++) begin
            e = (i % 2 == 0);
            g = (i == 15) ? 2'd1 : 2'd0;
            drv(1'b0, 1'b1, e, 1'b0, 1'b0, g, 1'b1, e, 1'b0, 1'b0, 1'b0, "acq_window_2");
        end
        for (int i = 0; i < 7; i++) begin
            e = (i % 2 == 0);
            drv(1'b0, 1'b1, e, (i == 2), 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, (i == 2), 1'b0, "trk_partial");
        end
        drv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_mid_window");

        // Fresh window: promotion only on the 16th post-reset sample
        for (int i = 0; i < 16; i++) begin
            e = (i % 2 == 0);
            g = (i == 15) ? 2'd1 : 2'd0;
            drv(1'b0, 1'b1, e, 1'b0, 1'b0, g, 1'b1, e, 1'b0, 1'b0, 1'b0, "acq_fresh_window");
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "tail_idle");

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
